fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: BRAM request issue, in-flight tracking, instruction queue and redirect squash.
// Define FETCH_PERF_EN to add the issued/squashed fetch counters.
module fetch_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     ADDR_W      = 12,
  parameter int unsigned     MEM_LATENCY = 2,
  parameter int unsigned     QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  output logic              imem_en_out,
  output logic [ADDR_W-1:0] imem_addr_out,
  input  logic [XLEN-1:0]   imem_data_in,
  input  logic              redirect_valid_in,
  input  logic [XLEN-1:0]   redirect_pc_in,
  output logic              inst_valid_out,
  input  logic              inst_ready_in,
  output logic [XLEN-1:0]   inst_out,
  output logic [XLEN-1:0]   pc_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       issued_count_out,
  output logic [31:0]       squashed_count_out
`endif
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned SUM_W = $clog2(QUEUE_DEPTH + MEM_LATENCY + 2) + 1;
  localparam int unsigned LAST  = MEM_LATENCY - 1;

  logic [XLEN-1:0]        fetch_pc;
  logic [XLEN-1:0]        req_pc;
  logic [MEM_LATENCY-1:0] fl_valid;
  logic [XLEN-1:0]        fl_pc  [MEM_LATENCY];
  logic [XLEN-1:0]        q_pc   [QUEUE_DEPTH];
  logic [XLEN-1:0]        q_inst [QUEUE_DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       count;

  logic                   pop, push, do_push, issue;
  logic [SUM_W-1:0]       inflight, occ_sum;
  logic [XLEN-1:0]        target_pc, issue_pc;
  logic [PTR_W-1:0]       rd_ptr_n, wr_ptr_n;
  logic [CNT_W-1:0]       count_n;
  logic                   head_valid_n;
  logic [XLEN-1:0]        head_pc_n, head_inst_n;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state: issue decision, queue pointers and the next head word.
  always_comb begin
    pop          = inst_valid_out && inst_ready_in;
    push         = fl_valid[LAST];
    do_push      = push && !redirect_valid_in;
    target_pc    = redirect_pc_in & ~XLEN'(3);
    inflight     = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight = inflight + SUM_W'(fl_valid[i]);
    end
    // The request on imem_en_out this cycle lands in stage 0, so it counts against capacity.
    occ_sum      = SUM_W'(count) + inflight + SUM_W'(imem_en_out) - SUM_W'(pop);
    // A redirect squashes the live request and the next one comes from the target.
    issue        = redirect_valid_in || (occ_sum < SUM_W'(QUEUE_DEPTH));
    issue_pc     = redirect_valid_in ? target_pc : fetch_pc;
    rd_ptr_n     = rd_ptr;
    wr_ptr_n     = wr_ptr;
    count_n      = count;
    head_valid_n = 1'b0;
    head_pc_n    = '0;
    head_inst_n  = '0;
    if (redirect_valid_in) begin
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      count_n  = '0;
    end else begin
      if (pop)  rd_ptr_n = ptr_inc(rd_ptr);
      if (push) wr_ptr_n = ptr_inc(wr_ptr);
      count_n = count + CNT_W'(push) - CNT_W'(pop);
      if (count_n != '0) begin
        head_valid_n = 1'b1;
        if (count == CNT_W'(pop)) begin
          head_pc_n   = fl_pc[LAST];
          head_inst_n = imem_data_in;
        end else begin
          head_pc_n   = q_pc[rd_ptr_n];
          head_inst_n = q_inst[rd_ptr_n];
        end
      end
    end
  end

  // Control state, in-flight pipeline and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fetch_pc       <= RESET_PC;
      req_pc         <= '0;
      imem_en_out    <= 1'b0;
      imem_addr_out  <= '0;
      fl_valid       <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) fl_pc[i] <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      inst_valid_out <= 1'b0;
      inst_out       <= '0;
      pc_out         <= '0;
    end else begin
      imem_en_out <= issue;
      if (issue) begin
        imem_addr_out <= issue_pc[ADDR_W+1:2];
        req_pc        <= issue_pc;
        fetch_pc      <= issue_pc + XLEN'(4);
      end
      fl_valid[0] <= imem_en_out && !redirect_valid_in;
      fl_pc[0]    <= req_pc;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        fl_valid[i] <= fl_valid[i-1] && !redirect_valid_in;
        fl_pc[i]    <= fl_pc[i-1];
      end
      rd_ptr         <= rd_ptr_n;
      wr_ptr         <= wr_ptr_n;
      count          <= count_n;
      inst_valid_out <= head_valid_n;
      inst_out       <= head_inst_n;
      pc_out         <= head_pc_n;
    end
  end

  // Queue storage; the head slot is mirrored into inst_out/pc_out.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      q_pc[wr_ptr]   <= fl_pc[LAST];
      q_inst[wr_ptr] <= imem_data_in;
    end
  end

`ifdef FETCH_PERF_EN
  // Squashed fetches include the request presented in the redirect cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      issued_count_out   <= '0;
      squashed_count_out <= '0;
    end else begin
      issued_count_out <= issued_count_out + 32'(imem_en_out);
      if (redirect_valid_in) begin
        squashed_count_out <= squashed_count_out + 32'(inflight) + 32'(imem_en_out) + 32'(count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset timing, streaming, backpressure, redirects, async reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_en;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
`ifdef FETCH_PERF_EN
  logic [31:0] issued_count;
  logic [31:0] squashed_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int issues;

  logic [31:0] mem [4096];
  logic [31:0] bram_r1, bram_r2;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .imem_en_out       (imem_en),
    .imem_addr_out     (imem_addr),
    .imem_data_in      (imem_data),
    .redirect_valid_in (redirect_valid),
    .redirect_pc_in    (redirect_pc),
    .inst_valid_out    (inst_valid),
    .inst_ready_in     (inst_ready),
    .inst_out          (inst),
    .pc_out            (pc)
`ifdef FETCH_PERF_EN
    ,
    .issued_count_out  (issued_count),
    .squashed_count_out(squashed_count)
`endif
  );

  // Two-cycle BRAM: address sampled, then output register.
  always @(posedge clk) begin
    bram_r1 <= imem_en ? mem[imem_addr] : 32'hDEAD_BEEF;
    bram_r2 <= bram_r1;
  end
  assign imem_data = bram_r2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic check_head(input string tag, input logic [31:0] exp_pc);
    check({tag, " valid"}, 32'(inst_valid), 32'd1);
    check({tag, " pc"}, pc, exp_pc);
    check({tag, " inst"}, inst, 32'h100 + (exp_pc >> 2));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " valid"}, 32'(inst_valid), 32'd0);
    check({tag, " inst"}, inst, 32'd0);
    check({tag, " pc"}, pc, 32'd0);
    check({tag, " en"}, 32'(imem_en), 32'd0);
    check({tag, " addr"}, 32'(imem_addr), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h100 + 32'(i);
    rst_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state, then first valid exactly four edges after release.
    @(negedge clk); @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("startup%0d valid", k), 32'(inst_valid), 32'd0);
      if (k == 1) begin
        check("first issue en", 32'(imem_en), 32'd1);
        check("first issue addr", 32'(imem_addr), 32'd0);
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_head($sformatf("stream%0d", i), 32'(4 * i));
    end

    // Backpressure from reset: four issues, then ordered drain with no gaps.
    inst_ready = 1'b0;
    do_reset();
    issues = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      issues += int'(imem_en);
    end
    check("bp issue count", 32'(issues), 32'd4);
    check_head("bp hold", 32'd0);
    inst_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_head($sformatf("bp drain%0d", k), 32'(4 * k));
    end

    // Redirect to 0x40 mid-stream, coincident with a pop.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("redir40 flush valid", 32'(inst_valid), 32'd0);
    check("redir40 en", 32'(imem_en), 32'd1);
    check("redir40 addr", 32'(imem_addr), 32'h10);
    @(negedge clk); check("redir40 t2 valid", 32'(inst_valid), 32'd0);
    @(negedge clk); check("redir40 t3 valid", 32'(inst_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_head($sformatf("redir40 s%0d", k), 32'h40 + 32'(4 * k));
    end

    // Fill the queue, then redirect to an unaligned target.
    inst_ready = 1'b0;
    for (int k = 0; k < 8; k++) @(negedge clk);
    check_head("full hold", 32'h4C);
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("redir43 flush valid", 32'(inst_valid), 32'd0);
    check("redir43 addr", 32'(imem_addr), 32'h10);
    @(negedge clk); check("redir43 t2 valid", 32'(inst_valid), 32'd0);
    @(negedge clk); check("redir43 t3 valid", 32'(inst_valid), 32'd0);
    @(negedge clk); check_head("redir43 head", 32'h40);
    for (int k = 0; k < 5; k++) @(negedge clk);
    check_head("redir43 stable", 32'h40);

    // Back-to-back redirects 0x80 then 0xC0; only the 0xC0 stream survives.
    inst_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_head($sformatf("pre b2b%0d", k), 32'h40 + 32'(4 * k));
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    redirect_pc = 32'hC0;
    check("b2b t1 valid", 32'(inst_valid), 32'd0);
    check("b2b t1 addr", 32'(imem_addr), 32'h20);
    @(negedge clk);
    redirect_valid = 1'b0;
    check("b2b t2 valid", 32'(inst_valid), 32'd0);
    check("b2b t2 en", 32'(imem_en), 32'd1);
    check("b2b t2 addr", 32'(imem_addr), 32'h30);
    @(negedge clk); check("b2b t3 valid", 32'(inst_valid), 32'd0);
    @(negedge clk); check("b2b t4 valid", 32'(inst_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_head($sformatf("b2b s%0d", k), 32'hC0 + 32'(4 * k));
    end

    // Asynchronous reset between edges, then restart from RESET_PC.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_zero("async rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("restart%0d valid", k), 32'(inst_valid), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_head($sformatf("restart s%0d", i), 32'(4 * i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
